quad_encoder_array: RTL and testbench

//  N-channel quadrature encoder front end; successor of the single-channel decoder/pulse-measure pair.
//  Per channel: 2-FF synchroniser, stability filter, x4 quadrature decode, signed wrapping position

---
 rtl/quad_encoder_array_if.sv | 27 ++
 rtl/quad_encoder_array.sv | 162 ++++++++++++++++
 tb/tb_quad_encoder_array.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_encoder_array_if.sv
// Encoder pin inputs, clear strobes and decoded position/velocity outputs
// for an N-channel quadrature front end.
interface quad_encoder_array_if #(
  parameter int N_CH  = 2,
  parameter int POS_W = 16,
  parameter int VEL_W = 12
);
  logic [N_CH-1:0]       enc_a;
  logic [N_CH-1:0]       enc_b;
  logic [N_CH-1:0]       pos_clr;
  logic [N_CH-1:0]       err_clr;
  logic [N_CH*POS_W-1:0] position;
  logic [N_CH*VEL_W-1:0] velocity;
  logic                  vel_valid;
  logic [N_CH-1:0]       dir;
  logic [N_CH-1:0]       err;

  modport master (
    output enc_a, enc_b, pos_clr, err_clr,
    input  position, velocity, vel_valid, dir, err
  );

  modport slave (
    input  enc_a, enc_b, pos_clr, err_clr,
    output position, velocity, vel_valid, dir, err
  );
endinterface

// File: rtl/quad_encoder_array.sv
// N-channel quadrature decoder: synchroniser, stability filter, x4 decode,
// wrapping position, sticky illegal-transition flag and windowed velocity.
module quad_encoder_array #(
  parameter int N_CH       = 2,
  parameter int POS_W      = 16,
  parameter int VEL_W      = 12,
  parameter int FILT_LEN   = 4,
  parameter int WINDOW_CYC = 50000
) (
  input  logic               clk_sys,
  input  logic               rst,
  quad_encoder_array_if.slave bus
);
  localparam int FC_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
  localparam int WC_W = $clog2(WINDOW_CYC);
  localparam logic [FC_W-1:0] FILT_LAST = FC_W'(FILT_LEN - 1);
  localparam logic [WC_W-1:0] WIN_LAST  = WC_W'(WINDOW_CYC - 1);
  localparam logic signed [VEL_W:0] SUM_MAX = (VEL_W+1)'((2 ** (VEL_W - 1)) - 1);
  localparam logic signed [VEL_W:0] SUM_MIN = (VEL_W+1)'(-(2 ** (VEL_W - 1)));

  // Position of an {A,B} state along the forward cycle 00->10->11->01.
  function automatic logic [1:0] phase_of(input logic [1:0] ab);
    logic [1:0] ph;
    case (ab)
      2'b00:   ph = 2'd0;
      2'b10:   ph = 2'd1;
      2'b11:   ph = 2'd2;
      2'b01:   ph = 2'd3;
      default: ph = 2'd0;
    endcase
    return ph;
  endfunction

  function automatic logic signed [VEL_W-1:0] sat_add(input logic signed [VEL_W-1:0] acc,
                                                      input logic signed [1:0]       step);
    logic signed [VEL_W:0] sum;
    logic signed [VEL_W-1:0] res;
    sum = (VEL_W+1)'(acc) + (VEL_W+1)'(step);
    if (sum > SUM_MAX) begin
      res = SUM_MAX[VEL_W-1:0];
    end else if (sum < SUM_MIN) begin
      res = SUM_MIN[VEL_W-1:0];
    end else begin
      res = sum[VEL_W-1:0];
    end
    return res;
  endfunction

  logic [1:0]              sync1_r  [N_CH];
  logic [1:0]              sync2_r  [N_CH];
  logic [1:0]              filt_r   [N_CH];
  logic [1:0]              prev_r   [N_CH];
  logic [FC_W-1:0]         fcnt_r   [N_CH];
  logic [POS_W-1:0]        pos_r    [N_CH];
  logic signed [VEL_W-1:0] acc_r    [N_CH];
  logic signed [VEL_W-1:0] vel_r    [N_CH];
  logic [N_CH-1:0]         dir_r;
  logic [N_CH-1:0]         err_r;
  logic                    vel_valid_r;
  logic [WC_W-1:0]         win_r;
  logic [1:0]              seed_r;

  logic                    seeding_s;
  logic                    win_last_s;
  logic [1:0]              delta_s   [N_CH];
  logic signed [1:0]       step_s    [N_CH];
  logic [N_CH-1:0]         illegal_s;
  logic signed [VEL_W-1:0] acc_sum_s [N_CH];

  // Decode the accepted filtered transition of each channel into a step or an illegal jump.
  always_comb begin
    seeding_s  = (seed_r != 2'd3);
    win_last_s = (win_r == WIN_LAST);
    illegal_s  = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      step_s[ch]  = 2'sb00;
      delta_s[ch] = phase_of(filt_r[ch]) - phase_of(prev_r[ch]);
      if (seeding_s) begin
        step_s[ch] = 2'sb00;
      end else begin
        case (delta_s[ch])
          2'd1:    step_s[ch] = 2'sb01;
          2'd3:    step_s[ch] = 2'sb11;
          2'd2:    illegal_s[ch] = 1'b1;
          default: step_s[ch] = 2'sb00;
        endcase
      end
      acc_sum_s[ch] = sat_add(acc_r[ch], step_s[ch]);
    end
  end

  // Channel state, shared window counter and seeding counter.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      seed_r      <= 2'd0;
      win_r       <= '0;
      vel_valid_r <= 1'b0;
      dir_r       <= '0;
      err_r       <= '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        sync1_r[ch] <= 2'b00;
        sync2_r[ch] <= 2'b00;
        filt_r[ch]  <= 2'b00;
        prev_r[ch]  <= 2'b00;
        fcnt_r[ch]  <= '0;
        pos_r[ch]   <= '0;
        acc_r[ch]   <= '0;
        vel_r[ch]   <= '0;
      end
    end else begin
      if (seeding_s) seed_r <= seed_r + 2'd1;
      win_r       <= win_last_s ? '0 : win_r + WC_W'(1);
      vel_valid_r <= win_last_s;
      for (int ch = 0; ch < N_CH; ch++) begin
        sync1_r[ch] <= {bus.enc_a[ch], bus.enc_b[ch]};
        sync2_r[ch] <= sync1_r[ch];
        // Seeding adopts the resting pin state so it never decodes as motion.
        if (seeding_s) begin
          filt_r[ch] <= sync2_r[ch];
          prev_r[ch] <= sync2_r[ch];
          fcnt_r[ch] <= '0;
        end else begin
          prev_r[ch] <= filt_r[ch];
          if (sync2_r[ch] != filt_r[ch]) begin
            if (fcnt_r[ch] == FILT_LAST) begin
              filt_r[ch] <= sync2_r[ch];
              fcnt_r[ch] <= '0;
            end else begin
              fcnt_r[ch] <= fcnt_r[ch] + FC_W'(1);
            end
          end else begin
            fcnt_r[ch] <= '0;
          end
        end
        if (bus.pos_clr[ch]) pos_r[ch] <= '0;
        else                 pos_r[ch] <= pos_r[ch] + POS_W'(step_s[ch]);
        if (step_s[ch] != 2'sb00) dir_r[ch] <= ~step_s[ch][1];
        if (illegal_s[ch])        err_r[ch] <= 1'b1;
        else if (bus.err_clr[ch]) err_r[ch] <= 1'b0;
        if (win_last_s) begin
          vel_r[ch] <= acc_sum_s[ch];
          acc_r[ch] <= '0;
        end else begin
          acc_r[ch] <= acc_sum_s[ch];
        end
      end
    end
  end

  // Pack per-channel registers onto the output bus.
  always_comb begin
    bus.position  = '0;
    bus.velocity  = '0;
    bus.vel_valid = vel_valid_r;
    bus.dir       = dir_r;
    bus.err       = err_r;
    for (int ch = 0; ch < N_CH; ch++) begin
      bus.position[ch*POS_W +: POS_W] = pos_r[ch];
      bus.velocity[ch*VEL_W +: VEL_W] = vel_r[ch];
    end
  end
endmodule

// File: tb/tb_quad_encoder_array.sv
// Two instances (16/12-bit and 8/4-bit) driven by identical encoder traffic;
// expected events are queued by the stimulus and consumed by a negedge monitor.
module tb_quad_encoder_array;
  localparam int F = 4;
  localparam int W = 100;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic       rst_q = 1'b1;
  logic [1:0] enc_a, enc_b, pos_clr, err_clr;
  int         n = 0;

  always #5 clk_sys = ~clk_sys;

  quad_encoder_array_if #(.N_CH(2), .POS_W(16), .VEL_W(12)) qif0 ();
  quad_encoder_array_if #(.N_CH(2), .POS_W(8),  .VEL_W(4))  qif1 ();

  assign qif0.enc_a = enc_a;   assign qif1.enc_a = enc_a;
  assign qif0.enc_b = enc_b;   assign qif1.enc_b = enc_b;
  assign qif0.pos_clr = pos_clr; assign qif1.pos_clr = pos_clr;
  assign qif0.err_clr = err_clr; assign qif1.err_clr = err_clr;

  quad_encoder_array #(.N_CH(2), .POS_W(16), .VEL_W(12), .FILT_LEN(F), .WINDOW_CYC(W)) dut0 (
    .clk_sys(clk_sys), .rst(rst), .bus(qif0));
  quad_encoder_array #(.N_CH(2), .POS_W(8), .VEL_W(4), .FILT_LEN(F), .WINDOW_CYC(W)) dut1 (
    .clk_sys(clk_sys), .rst(rst), .bus(qif1));

  // Edge number since the last reset edge, plus the reset level seen at that edge.
  always @(posedge clk_sys) begin
    rst_q <= rst;
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  typedef struct {int val; int at;} ev_t;
  ev_t        ev_q [2][2][3][$];   // [instance][channel][0=position,1=err,2=dir]
  int         last_v [2][2][3];
  int         vacc [int];          // saturating step sum per (window, channel, instance)
  int         pos_m [2][2];
  int         dir_m [2];
  int         err_m [2];
  int         ph [2];
  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic int pw(int inst); return (inst == 0) ? 16 : 8; endfunction
  function automatic int vw(int inst); return (inst == 0) ? 12 : 4; endfunction
  function automatic int vkey(int m, int ch, int inst); return (m * 2 + ch) * 2 + inst; endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, n);
    end
  endtask

  function automatic int obs(int inst, int ch, int kind);
    int v;
    case (kind)
      0:       v = (inst == 0) ? int'(qif0.position[ch*16 +: 16]) : int'(qif1.position[ch*8 +: 8]);
      1:       v = (inst == 0) ? int'(qif0.err[ch]) : int'(qif1.err[ch]);
      default: v = (inst == 0) ? int'(qif0.dir[ch]) : int'(qif1.dir[ch]);
    endcase
    return v;
  endfunction

  function automatic int obs_vel(int inst, int ch);
    logic signed [11:0] v12;
    logic signed [3:0]  v4;
    v12 = qif0.velocity[ch*12 +: 12];
    v4  = qif1.velocity[ch*4 +: 4];
    return (inst == 0) ? int'(v12) : int'(v4);
  endfunction

  function automatic string kname(int kind);
    return (kind == 0) ? "position" : ((kind == 1) ? "err" : "dir");
  endfunction

  // ---------------- reference model ----------------
  task automatic push_ev(int inst, int ch, int kind, int val, int at);
    ev_t e;
    e.val = val;
    e.at  = at;
    ev_q[inst][ch][kind].push_back(e);
  endtask

  task automatic model_step(int ch, int d, int u, bit clr);
    for (int i = 0; i < 2; i++) begin
      int np, key, v, hi, lo;
      np = clr ? 0 : ((pos_m[i][ch] + d) & ((1 << pw(i)) - 1));
      if (np != pos_m[i][ch]) begin
        push_ev(i, ch, 0, np, u);
        pos_m[i][ch] = np;
      end
      hi  = (1 << (vw(i) - 1)) - 1;
      lo  = -(1 << (vw(i) - 1));
      key = vkey((u + W - 1) / W, ch, i);
      v   = vacc.exists(key) ? vacc[key] : 0;
      v   = v + d;
      if (v > hi) v = hi;
      if (v < lo) v = lo;
      vacc[key] = v;
    end
    if (((d > 0) ? 1 : 0) != dir_m[ch]) begin
      dir_m[ch] = (d > 0) ? 1 : 0;
      for (int i = 0; i < 2; i++) push_ev(i, ch, 2, dir_m[ch], u);
    end
  endtask

  task automatic model_clr(int ch, int at);
    for (int i = 0; i < 2; i++) begin
      if (pos_m[i][ch] != 0) begin
        push_ev(i, ch, 0, 0, at);
        pos_m[i][ch] = 0;
      end
    end
  endtask

  task automatic model_err(int ch, int val, int at);
    if (err_m[ch] != val) begin
      err_m[ch] = val;
      for (int i = 0; i < 2; i++) push_ev(i, ch, 1, val, at);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic tick(int k);
    repeat (k) @(posedge clk_sys);
    #1;
  endtask

  task automatic drive_pins();
    logic [1:0] s0, s1;
    s0 = seq[ph[0]];
    s1 = seq[ph[1]];
    enc_a = {s1[1], s0[1]};
    enc_b = {s1[0], s0[0]};
  endtask

  // act: 0 idle, 1 forward, 2 reverse, 3 illegal jump. Pins settle; effects land F+2 edges after sampling.
  task automatic slot(int a0, int a1, logic [1:0] clr, logic [1:0] eclr, int hold);
    int c, u;
    c = n;
    u = c + F + 3;
    pos_clr = clr;
    err_clr = eclr;
    for (int ch = 0; ch < 2; ch++) begin
      if (clr[ch])  model_clr(ch, c + 1);
      if (eclr[ch]) model_err(ch, 0, c + 1);
    end
    for (int ch = 0; ch < 2; ch++) begin
      case ((ch == 0) ? a0 : a1)
        1: begin ph[ch] = (ph[ch] + 1) % 4; model_step(ch, 1, u, 1'b0); end
        2: begin ph[ch] = (ph[ch] + 3) % 4; model_step(ch, -1, u, 1'b0); end
        3: begin ph[ch] = (ph[ch] + 2) % 4; model_err(ch, 1, u); end
        default: ;
      endcase
    end
    drive_pins();
    tick(1);
    pos_clr = 2'b00;
    err_clr = 2'b00;
    tick(hold - 1);
  endtask

  // A level held for len sampled cycles is accepted only when len >= F.
  task automatic pulse(int ch, int len, int d);
    int c;
    c = n;
    if (len >= F) begin
      model_step(ch, d, c + F + 3, 1'b0);
      model_step(ch, -d, c + len + F + 3, 1'b0);
    end
    ph[ch] = (ph[ch] + 4 + d) % 4;
    drive_pins();
    tick(len);
    ph[ch] = (ph[ch] + 4 - d) % 4;
    drive_pins();
    tick(F + 4);
  endtask

  task automatic clr_with_step(int ch);
    int c;
    c = n;
    ph[ch] = (ph[ch] + 1) % 4;
    model_step(ch, 1, c + F + 3, 1'b1);
    drive_pins();
    tick(F + 2);
    pos_clr[ch] = 1'b1;
    tick(1);
    pos_clr = 2'b00;
    tick(4);
  endtask

  task automatic illegal_with_clr(int ch);
    int c;
    c = n;
    ph[ch] = (ph[ch] + 2) % 4;
    model_err(ch, 1, c + F + 3);
    drive_pins();
    tick(F + 2);
    err_clr[ch] = 1'b1;
    tick(1);
    err_clr = 2'b00;
    tick(4);
  endtask

  task automatic align(int p);
    int guard;
    guard = 0;
    while ((n % W) != p && guard < 2 * W) begin
      tick(1);
      guard++;
    end
  endtask

  task automatic random_slot();
    int a0, a1;
    logic [1:0] clr, eclr;
    a0 = $urandom_range(0, 2);
    a1 = $urandom_range(0, 2);
    if ($urandom_range(0, 15) == 0) a0 = 3;
    if ($urandom_range(0, 15) == 0) a1 = 3;
    clr  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    eclr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    if ($urandom_range(0, 9) == 0)
      pulse($urandom_range(0, 1), $urandom_range(1, F + 2), ($urandom_range(0, 1) == 1) ? 1 : -1);
    else
      slot(a0, a1, clr, eclr, $urandom_range(F + 3, F + 9));
  endtask

  task automatic check_drained(string name);
    for (int i = 0; i < 2; i++)
      for (int ch = 0; ch < 2; ch++)
        for (int k = 0; k < 3; k++)
          check({name, "_", kname(k)}, ev_q[i][ch][k].size(), 0);
  endtask

  task automatic do_reset();
    tick(F + 6);
    check_drained("pending_before_reset");
    ph[0] = $urandom_range(0, 3);
    ph[1] = $urandom_range(0, 3);
    drive_pins();
    rst = 1'b1;
    tick(3);
    for (int i = 0; i < 2; i++)
      for (int ch = 0; ch < 2; ch++) begin
        pos_m[i][ch] = 0;
        for (int k = 0; k < 3; k++) ev_q[i][ch][k].delete();
      end
    vacc.delete();
    dir_m = '{0, 0};
    err_m = '{0, 0};
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    forever begin
      @(negedge clk_sys);
      if (rst_q) begin
        for (int i = 0; i < 2; i++) begin
          check("reset_vel_valid", (i == 0) ? int'(qif0.vel_valid) : int'(qif1.vel_valid), 0);
          for (int ch = 0; ch < 2; ch++) begin
            check("reset_velocity", obs_vel(i, ch), 0);
            for (int k = 0; k < 3; k++) begin
              last_v[i][ch][k] = obs(i, ch, k);
              check({"reset_", kname(k)}, last_v[i][ch][k], 0);
            end
          end
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          int vv;
          bit want;
          vv   = (i == 0) ? int'(qif0.vel_valid) : int'(qif1.vel_valid);
          want = ((n % W) == 0);
          check("vel_valid", vv, int'(want));
          if (want) begin
            for (int ch = 0; ch < 2; ch++) begin
              int key;
              key = vkey(n / W, ch, i);
              check($sformatf("velocity i%0d ch%0d", i, ch), obs_vel(i, ch),
                    vacc.exists(key) ? vacc[key] : 0);
            end
          end
          for (int ch = 0; ch < 2; ch++) begin
            for (int k = 0; k < 3; k++) begin
              int v;
              v = obs(i, ch, k);
              while (ev_q[i][ch][k].size() > 0 && ev_q[i][ch][k][0].at < n) begin
                check($sformatf("missed_%s i%0d ch%0d edge", kname(k), i, ch), n, ev_q[i][ch][k][0].at);
                void'(ev_q[i][ch][k].pop_front());
              end
              if (v != last_v[i][ch][k]) begin
                if (ev_q[i][ch][k].size() == 0) begin
                  check($sformatf("unexpected_%s i%0d ch%0d", kname(k), i, ch), v, last_v[i][ch][k]);
                end else begin
                  ev_t e;
                  e = ev_q[i][ch][k].pop_front();
                  check($sformatf("%s i%0d ch%0d value", kname(k), i, ch), v, e.val);
                  check($sformatf("%s i%0d ch%0d edge", kname(k), i, ch), n, e.at);
                end
                last_v[i][ch][k] = v;
              end
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin : stim
    rst = 1'b1;
    enc_a = 2'b00; enc_b = 2'b00; pos_clr = 2'b00; err_clr = 2'b00;
    ph = '{0, 0}; dir_m = '{0, 0}; err_m = '{0, 0};
    pos_m = '{'{0, 0}, '{0, 0}};
    tick(4);
    rst = 1'b0;
    tick(6);

    repeat (4) slot(1, 0, 2'b00, 2'b00, 10);            // forward +4, ch1 idle
    slot(0, 0, 2'b01, 2'b00, F + 3);
    repeat (8) slot(2, 0, 2'b00, 2'b00, F + 3);         // reverse to -8

    pulse(0, F - 1, 1);                                 // glitch rejected
    pulse(0, F, 1);                                     // shortest accepted level
    pulse(1, F - 1, -1);
    pulse(1, F + 1, -1);

    slot(0, 3, 2'b00, 2'b00, F + 3);                    // illegal on ch1
    slot(0, 0, 2'b00, 2'b10, F + 3);
    illegal_with_clr(1);                                // set wins over clear
    slot(0, 0, 2'b00, 2'b10, F + 3);

    align(1);
    repeat (10) slot(1, 0, 2'b00, 2'b00, 9);
    tick(2 * W);                                        // following window is idle
    align(1);
    repeat (9) slot(1, 2, 2'b00, 2'b00, F + 3);         // saturates the 4-bit instance
    tick(W);

    slot(0, 0, 2'b11, 2'b00, F + 3);
    repeat (128) slot(1, 0, 2'b00, 2'b00, F + 3);       // 8-bit wrap 127 -> -128
    clr_with_step(0);
    clr_with_step(1);

    repeat (150) random_slot();

    align(50);
    do_reset();                                         // mid-window reset
    tick(2 * W + 20);
    repeat (10) random_slot();
    tick(F + 6);
    check_drained("pending_at_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
